// File: rtl/fifo_vc_arbiter_pkg.sv
// Shared definitions for the virtual-channel FIFO arbiter: FSM encodings,
// channel count, destination field position and reset thresholds.
package fifo_vc_arbiter_pkg;

    localparam int VC_DATA_W = 12;
    localparam int VC_NUM    = 4;
    localparam int DEST_HI   = VC_DATA_W - 1;
    localparam int DEST_LO   = VC_DATA_W - 2;

    localparam logic [7:0] UMBRAL_BAJO_RST = 8'd1;
    localparam logic [7:0] UMBRAL_ALTO_RST = 8'd6;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // One-hot write enable for the output FIFO named by a destination field.
    function automatic logic [VC_NUM-1:0] dest_onehot(input logic [1:0] dest);
        return {{(VC_NUM-1){1'b0}}, 1'b1} << dest;
    endfunction

endpackage

// File: rtl/fifo_vc_arbiter_rr.sv
// Four-way round-robin arbiter: grants the first requester found scanning
// upward from ptr (wrapping), purely combinational.
module fifo_vc_arbiter_rr (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [3:0] o_grant,
    output logic [1:0] o_grant_idx,
    output logic       o_valid
);

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        logic [1:0] w_idx;
        o_grant     = 4'b0000;
        o_grant_idx = i_ptr;
        o_valid     = 1'b0;
        w_idx       = i_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = i_ptr + 2'(k);
            if (i_req[w_idx]) begin
                o_valid     = 1'b1;
                o_grant_idx = w_idx;
            end
        end
        if (o_valid) begin
            o_grant = 4'b0001 << o_grant_idx;
        end
    end

endmodule

// File: rtl/fifo_vc_arbiter.sv
// Pops four input VC FIFOs round-robin and routes each popped word to the
// output FIFO chosen by its destination bits; a control FSM handles
// threshold configuration, idle detection and sticky error lock-up.
module fifo_vc_arbiter
    import fifo_vc_arbiter_pkg::*;
#(
    parameter int         TAMANO_DATOS    = VC_DATA_W,
    parameter int         NUM_VC          = VC_NUM,
    parameter logic [7:0] UMBRAL_BAJO_DEF = UMBRAL_BAJO_RST,
    parameter logic [7:0] UMBRAL_ALTO_DEF = UMBRAL_ALTO_RST
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           init,
    input  logic [7:0]                     umbral_bajo_in,
    input  logic [7:0]                     umbral_alto_in,
    input  logic [NUM_VC-1:0]              in_empty,
    input  logic [NUM_VC-1:0]              in_error,
    input  logic [NUM_VC*TAMANO_DATOS-1:0] in_data,
    input  logic [NUM_VC-1:0]              out_almost_full,
    input  logic [NUM_VC-1:0]              out_error,
    output logic [NUM_VC-1:0]              pop,
    output logic [NUM_VC-1:0]              push,
    output logic [TAMANO_DATOS-1:0]        out_data,
    output logic [7:0]                     umbral_bajo,
    output logic [7:0]                     umbral_alto,
    output logic [2:0]                     state,
    output logic                           idle,
    output logic                           error_out
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [NUM_VC-1:0]       r_pop;
    logic [NUM_VC-1:0]       r_push;
    logic [TAMANO_DATOS-1:0] r_out_data;
    logic [7:0]              r_umbral_bajo;
    logic [7:0]              r_umbral_alto;
    logic                    r_idle;
    logic                    r_error;
    logic [1:0]              r_rr;
    logic [1:0]              r_pop_idx;
    logic                    r_valid;

    logic                    w_err;
    logic [NUM_VC-1:0]       w_req;
    logic [NUM_VC-1:0]       w_grant;
    logic [1:0]              w_grant_idx;
    logic                    w_grant_valid;
    logic                    w_pop_en;
    logic [TAMANO_DATOS-1:0] w_vc_data [NUM_VC];
    logic [TAMANO_DATOS-1:0] w_slice;

    assign w_err = (|in_error) | (|out_error);
    assign w_req = ~in_empty;

    // Split the concatenated FIFO outputs into one word per channel.
    generate
        for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_slice
            assign w_vc_data[gi] = in_data[gi*TAMANO_DATOS +: TAMANO_DATOS];
        end
    endgenerate

    // Word being popped this cycle; it is captured at the end of the pop cycle.
    assign w_slice = w_vc_data[r_pop_idx];

    fifo_vc_arbiter_rr u_rr (
        .i_req       (w_req),
        .i_ptr       (r_rr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_valid     (w_grant_valid)
    );

    // Pops stop while init is pending so the pipeline can drain before INIT.
    // Backpressure is sampled here, at decision time, so the in-flight word
    // always has a slot below the almost_full threshold.
    assign w_pop_en = (r_state == ST_ACTIVE) && !w_err && !init &&
                      !(|out_almost_full) && w_grant_valid;

    // Next-state selection for the control FSM.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RESET:  w_state_next = ST_INIT;
            ST_INIT:   if (!init) w_state_next = ST_IDLE;
            ST_IDLE: begin
                if (w_err)          w_state_next = ST_ERROR;
                else if (init)      w_state_next = ST_INIT;
                else if (|w_req)    w_state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (w_err)                        w_state_next = ST_ERROR;
                else if (init && !r_valid)        w_state_next = ST_INIT;
                else if (!(|w_req) && !r_valid)   w_state_next = ST_IDLE;
            end
            ST_ERROR:  w_state_next = ST_ERROR;
            default:   w_state_next = ST_RESET;
        endcase
    end

    // State, thresholds, arbitration pointer, pop and push/data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RESET;
            r_idle        <= 1'b0;
            r_error       <= 1'b0;
            r_umbral_bajo <= UMBRAL_BAJO_DEF;
            r_umbral_alto <= UMBRAL_ALTO_DEF;
            r_pop         <= '0;
            r_push        <= '0;
            r_out_data    <= '0;
            r_rr          <= 2'd0;
            r_pop_idx     <= 2'd0;
            r_valid       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idle  <= (w_state_next == ST_IDLE);
            r_error <= (w_state_next == ST_ERROR);

            if (r_state == ST_INIT) begin
                r_umbral_bajo <= umbral_bajo_in;
                r_umbral_alto <= umbral_alto_in;
            end

            r_valid <= w_pop_en;
            r_pop   <= w_pop_en ? w_grant : '0;
            if (w_pop_en) begin
                r_pop_idx <= w_grant_idx;
                r_rr      <= w_grant_idx + 2'd1;
            end

            // An error arriving with a word in flight drops that word.
            if (r_valid && (r_state == ST_ACTIVE) && !w_err) begin
                r_push     <= dest_onehot(w_slice[DEST_HI:DEST_LO]);
                r_out_data <= w_slice;
            end else begin
                r_push     <= '0;
            end
        end
    end

    assign pop         = r_pop;
    assign push        = r_push;
    assign out_data    = r_out_data;
    assign umbral_bajo = r_umbral_bajo;
    assign umbral_alto = r_umbral_alto;
    assign state       = r_state;
    assign idle        = r_idle;
    assign error_out   = r_error;

endmodule

// File: tb/tb_fifo_vc_arbiter.sv
// Directed bench for fifo_vc_arbiter: reset/config, single word, round-robin
// order, backpressure, error lock-up and reset during a transfer.
module tb_fifo_vc_arbiter;

    logic        clk;
    logic        reset;
    logic        init;
    logic [7:0]  umbral_bajo_in;
    logic [7:0]  umbral_alto_in;
    logic [3:0]  in_empty;
    logic [3:0]  in_error;
    logic [47:0] in_data;
    logic [3:0]  out_almost_full;
    logic [3:0]  out_error;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [11:0] out_data;
    logic [7:0]  umbral_bajo;
    logic [7:0]  umbral_alto;
    logic [2:0]  state;
    logic        idle;
    logic        error_out;

    int checks;
    int failures;
    int vc_cnt [4];

    fifo_vc_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .init            (init),
        .umbral_bajo_in  (umbral_bajo_in),
        .umbral_alto_in  (umbral_alto_in),
        .in_empty        (in_empty),
        .in_error        (in_error),
        .in_data         (in_data),
        .out_almost_full (out_almost_full),
        .out_error       (out_error),
        .pop             (pop),
        .push            (push),
        .out_data        (out_data),
        .umbral_bajo     (umbral_bajo),
        .umbral_alto     (umbral_alto),
        .state           (state),
        .idle            (idle),
        .error_out       (error_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Load a channel's occupancy and the word it presents.
    task automatic set_vc(input int vc, input int cnt, input logic [11:0] word);
        vc_cnt[vc] = cnt;
        in_data[vc*12 +: 12] = word;
        in_empty[vc] = (cnt == 0);
    endtask

    // Advance one clock and sample 1 time unit after the edge. The input
    // FIFO model counts a word as consumed as soon as its pop is visible.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (pop[i] && vc_cnt[i] > 0) vc_cnt[i] = vc_cnt[i] - 1;
            in_empty[i] = (vc_cnt[i] == 0);
        end
    endtask

    task automatic do_reset_init();
        for (int i = 0; i < 4; i++) set_vc(i, 0, 12'h000);
        reset = 1'b1; init = 1'b0;
        tick();
        reset = 1'b0; init = 1'b1;
        umbral_bajo_in = 8'd2; umbral_alto_in = 8'd5;
        tick();
        init = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) set_vc(i, 0, 12'h000);
        reset = 1'b1; init = 1'b0;
        tick();
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (pop !== 4'b0 || push !== 4'b0) begin failures++; $display("FAIL reset_pop_push got pop=%b push=%b exp=0", pop, push); end
        checks++; if (out_data !== 12'h000) begin failures++; $display("FAIL reset_out_data got=%h exp=000", out_data); end
        checks++; if (umbral_bajo !== 8'd1 || umbral_alto !== 8'd6) begin failures++; $display("FAIL reset_umbral got=%0d/%0d exp=1/6", umbral_bajo, umbral_alto); end
        checks++; if (idle !== 1'b0 || error_out !== 1'b0) begin failures++; $display("FAIL reset_flags got idle=%b err=%b exp=0/0", idle, error_out); end
        reset = 1'b0; init = 1'b1;
        umbral_bajo_in = 8'd2; umbral_alto_in = 8'd5;
        tick();
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL init_state got=%0d exp=1", state); end
        tick();
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL init_hold got=%0d exp=1", state); end
        init = 1'b0;
        tick();
        checks++; if (state !== 3'd2 || idle !== 1'b1) begin failures++; $display("FAIL init_to_idle got state=%0d idle=%b exp=2/1", state, idle); end
        checks++; if (umbral_bajo !== 8'd2 || umbral_alto !== 8'd5) begin failures++; $display("FAIL init_umbral got=%0d/%0d exp=2/5", umbral_bajo, umbral_alto); end
        checks++; if (pop !== 4'b0 || push !== 4'b0) begin failures++; $display("FAIL init_pop_push got pop=%b push=%b exp=0", pop, push); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset_init();
        set_vc(1, 1, 12'hA5C);
        tick();
        checks++; if (state !== 3'd3 || pop !== 4'b0) begin failures++; $display("FAIL single_active got state=%0d pop=%b exp=3/0000", state, pop); end
        tick();
        checks++; if (pop !== 4'b0010) begin failures++; $display("FAIL single_pop got=%b exp=0010", pop); end
        tick();
        checks++; if (push !== 4'b0100 || out_data !== 12'hA5C) begin failures++; $display("FAIL single_push got push=%b data=%h exp=0100/a5c", push, out_data); end
        checks++; if (pop !== 4'b0) begin failures++; $display("FAIL single_no_repop got=%b exp=0000", pop); end
        tick();
        checks++; if (state !== 3'd2 || idle !== 1'b1 || push !== 4'b0) begin failures++; $display("FAIL single_back_idle got state=%0d idle=%b push=%b exp=2/1/0000", state, idle, push); end
        $display("test_single pop=0010 push=0100 data=a5c");
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_pop  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
        logic [3:0]  exp_push [6] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [11:0] exp_data [6] = '{12'h000, 12'hC01, 12'h012, 12'h423, 12'h834, 12'hC01};
        do_reset_init();
        set_vc(0, 2, 12'hC01);
        set_vc(1, 1, 12'h012);
        set_vc(2, 1, 12'h423);
        set_vc(3, 1, 12'h834);
        tick();
        for (int c = 0; c < 6; c++) begin
            tick();
            $display("rr cycle %0d pop=%b push=%b data=%h", c, pop, push, out_data);
            checks++; if (pop !== exp_pop[c]) begin failures++; $display("FAIL rr_pop[%0d] got=%b exp=%b", c, pop, exp_pop[c]); end
            checks++; if (push !== exp_push[c]) begin failures++; $display("FAIL rr_push[%0d] got=%b exp=%b", c, push, exp_push[c]); end
            if (c > 0) begin
                checks++; if (out_data !== exp_data[c]) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", c, out_data, exp_data[c]); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset_init();
        set_vc(0, 10, 12'h801);
        tick();
        tick();
        checks++; if (pop !== 4'b0001) begin failures++; $display("FAIL bp_first_pop got=%b exp=0001", pop); end
        out_almost_full = 4'b0100;
        tick();
        checks++; if (push !== 4'b0100 || out_data !== 12'h801) begin failures++; $display("FAIL bp_inflight_push got push=%b data=%h exp=0100/801", push, out_data); end
        checks++; if (pop !== 4'b0) begin failures++; $display("FAIL bp_hold0 got=%b exp=0000", pop); end
        for (int c = 1; c < 3; c++) begin
            tick();
            checks++; if (pop !== 4'b0 || push !== 4'b0) begin failures++; $display("FAIL bp_hold%0d got pop=%b push=%b exp=0", c, pop, push); end
        end
        out_almost_full = 4'b0000;
        tick();
        checks++; if (pop !== 4'b0001) begin failures++; $display("FAIL bp_resume got=%b exp=0001", pop); end
        set_vc(0, 0, 12'h801);
        $display("test_backpressure done");
    endtask

    task automatic test_error();
        do_reset_init();
        set_vc(0, 10, 12'h001);
        tick();
        tick();
        checks++; if (pop !== 4'b0001) begin failures++; $display("FAIL err_pre_pop got=%b exp=0001", pop); end
        in_error = 4'b1000;
        tick();
        in_error = 4'b0000;
        checks++; if (state !== 3'd4 || error_out !== 1'b1) begin failures++; $display("FAIL err_enter got state=%0d err=%b exp=4/1", state, error_out); end
        checks++; if (pop !== 4'b0 || push !== 4'b0) begin failures++; $display("FAIL err_suppress got pop=%b push=%b exp=0", pop, push); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (state !== 3'd4 || pop !== 4'b0 || push !== 4'b0) begin failures++; $display("FAIL err_sticky%0d got state=%0d pop=%b push=%b exp=4/0/0", c, state, pop, push); end
        end
        set_vc(0, 0, 12'h001);
        reset = 1'b1;
        tick();
        checks++; if (state !== 3'd0 || error_out !== 1'b0) begin failures++; $display("FAIL err_reset got state=%0d err=%b exp=0/0", state, error_out); end
        reset = 1'b0;
        tick();
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL err_to_init got=%0d exp=1", state); end
        tick();
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL err_to_idle got=%0d exp=2", state); end
        $display("test_error done");
    endtask

    task automatic test_reset_mid();
        do_reset_init();
        set_vc(2, 1, 12'hC22);
        tick();
        tick();
        checks++; if (pop !== 4'b0100) begin failures++; $display("FAIL mid_pop got=%b exp=0100", pop); end
        reset = 1'b1;
        tick();
        checks++; if (push !== 4'b0 || out_data !== 12'h000) begin failures++; $display("FAIL mid_drop got push=%b data=%h exp=0/000", push, out_data); end
        checks++; if (umbral_bajo !== 8'd1 || umbral_alto !== 8'd6) begin failures++; $display("FAIL mid_umbral got=%0d/%0d exp=1/6", umbral_bajo, umbral_alto); end
        checks++; if (state !== 3'd0 || pop !== 4'b0) begin failures++; $display("FAIL mid_state got state=%0d pop=%b exp=0/0", state, pop); end
        reset = 1'b0;
        tick();
        $display("test_reset_mid done");
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; init = 1'b0;
        umbral_bajo_in = 8'd0; umbral_alto_in = 8'd0;
        in_empty = 4'hF; in_error = 4'h0; in_data = '0;
        out_almost_full = 4'h0; out_error = 4'h0;
        for (int i = 0; i < 4; i++) vc_cnt[i] = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_error();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
